// File: rtl/nibble_shift_ctrl.sv
// nibble_shift_ctrl: parallel-to-serial nibble serializer.
// Takes a STAGES*4-bit word on a valid/ready handshake and sends it out MSB
// nibble first on a second valid/ready handshake. A new word can be taken on
// the last beat of a frame, so frames stream back-to-back with no bubble.
// Optional build macro NIBBLE_SHIFT_ROTATE_EN: on each shift, stage 0 takes
// the old top stage instead of zero. After an isolated frame the chain then
// holds the original word again. The serial stream is the same in both builds.
module nibble_shift_ctrl #(
  parameter  int STAGES = 4,
  localparam int CNT_W  = $clog2(STAGES)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [4*STAGES-1:0] in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [3:0]          out_nibble,
  output logic                out_last,
  output logic                load_en,
  output logic                shift_en,
  output logic [4*STAGES-1:0] chain_q,
  output logic [7:0]          frame_count
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SEND = 1'b1;

  logic [0:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       stage_q [STAGES];

  logic is_send;
  logic is_last;
  logic out_fire;

  assign is_send  = (state == ST_SEND);
  assign is_last  = (cnt == CNT_W'(STAGES - 1));
  assign out_fire = is_send && out_ready;

  // Handshake and chain strobes; everything is held quiet while reset is high.
  // A load on the last beat takes priority over the final shift.
  always_comb begin
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    load_en    = 1'b0;
    shift_en   = 1'b0;
    out_last   = is_send && is_last;
    out_nibble = stage_q[STAGES-1];
    if (!rst) begin
      in_ready  = !is_send || (is_last && out_ready);
      out_valid = is_send;
      load_en   = in_ready && in_valid;
      shift_en  = out_fire && !(is_last && in_valid);
    end
  end

  // Flatten the stage array for debug; stage i sits at bits [4i+3:4i].
  always_comb begin
    chain_q = '0;
    for (int i = 0; i < STAGES; i++) begin
      chain_q[4*i +: 4] = stage_q[i];
    end
  end

  // Stage chain: reset clears, load captures the word, shift moves toward the top.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) begin
        stage_q[i] <= 4'h0;
      end
    end else if (load_en) begin
      for (int i = 0; i < STAGES; i++) begin
        stage_q[i] <= in_data[4*i +: 4];
      end
    end else if (shift_en) begin
      for (int i = 1; i < STAGES; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
`ifdef NIBBLE_SHIFT_ROTATE_EN
      stage_q[0] <= stage_q[STAGES-1];
`else
      stage_q[0] <= 4'h0;
`endif
    end
  end

  // Sequencing: beat counter and IDLE/SEND state follow the chain strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else if (load_en) begin
      state <= ST_SEND;
      cnt   <= '0;
    end else if (shift_en) begin
      if (is_last) begin
        state <= ST_IDLE;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  // Completed-frame counter, bumped when the last beat is taken; wraps at 256.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_count <= 8'h00;
    end else if (out_fire && is_last) begin
      frame_count <= frame_count + 8'h01;
    end
  end

endmodule

// File: tb/tb_nibble_shift_ctrl.sv
// tb_nibble_shift_ctrl: directed self-checking bench for nibble_shift_ctrl
// with STAGES=4. Expected values are hand-derived from the frame words.
module tb_nibble_shift_ctrl;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_nibble;
  logic        out_last;
  logic        load_en;
  logic        shift_en;
  logic [15:0] chain_q;
  logic [7:0]  frame_count;

  int checkCount = 0;
  int passCount  = 0;

  nibble_shift_ctrl #(.STAGES(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_nibble  (out_nibble),
    .out_last    (out_last),
    .load_en     (load_en),
    .shift_en    (shift_en),
    .chain_q     (chain_q),
    .frame_count (frame_count)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle's inputs on the falling edge, then let outputs settle.
  task automatic applyStimulus(input logic r, input logic iv,
                               input logic [15:0] d, input logic ordy);
    @(negedge clk);
    rst       = r;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    #1;
  endtask

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: observed %0h expected %0h at %0t",
               tag, observed, expected, $time);
    end
  endtask

  // Sends a whole frame with out_ready high and checks every beat.
  task automatic checkFrame(input string tag, input logic [15:0] word);
    logic [3:0] nib;
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1);
      nib = word[15-4*k -: 4];
      checkOutput({tag, " valid"}, 32'(out_valid), 32'd1);
      checkOutput({tag, " nibble"}, 32'(out_nibble), 32'(nib));
      checkOutput({tag, " last"}, 32'(out_last), (k == 3) ? 32'd1 : 32'd0);
      checkOutput({tag, " shift_en"}, 32'(shift_en), 32'd1);
    end
  endtask

  logic [15:0] idleChain;
  logic [15:0] word2;

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = 16'h0000; out_ready = 1'b1;

    // Reset held two cycles
    applyStimulus(1'b1, 1'b0, 16'h0000, 1'b1);
    checkOutput("rst out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst in_ready", 32'(in_ready), 32'd0);
    applyStimulus(1'b1, 1'b1, 16'hBEEF, 1'b1);
    checkOutput("rst in_ready w/ valid", 32'(in_ready), 32'd0);
    checkOutput("rst load_en", 32'(load_en), 32'd0);
    checkOutput("rst chain_q", 32'(chain_q), 32'h0000);
    checkOutput("rst frame_count", 32'(frame_count), 32'd0);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1);
    checkOutput("post-rst in_ready", 32'(in_ready), 32'd1);
    checkOutput("post-rst out_valid", 32'(out_valid), 32'd0);

    // Single frame A5C3
`ifdef NIBBLE_SHIFT_ROTATE_EN
    idleChain = 16'hA5C3;
`else
    idleChain = 16'h0000;
`endif
    applyStimulus(1'b0, 1'b1, 16'hA5C3, 1'b1);
    checkOutput("s2 load_en", 32'(load_en), 32'd1);
    checkOutput("s2 shift_en idle", 32'(shift_en), 32'd0);
    checkFrame("s2", 16'hA5C3);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1);
    checkOutput("s2 idle out_valid", 32'(out_valid), 32'd0);
    checkOutput("s2 idle in_ready", 32'(in_ready), 32'd1);
    checkOutput("s2 frame_count", 32'(frame_count), 32'd1);
    checkOutput("s2 chain_q", 32'(chain_q), 32'(idleChain));

    // Stall on nibble 5 for three cycles
    applyStimulus(1'b0, 1'b1, 16'hA5C3, 1'b1);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1);
    checkOutput("s3 nibble A", 32'(out_nibble), 32'hA);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);
      checkOutput("s3 stall nibble", 32'(out_nibble), 32'h5);
      checkOutput("s3 stall valid", 32'(out_valid), 32'd1);
      checkOutput("s3 stall shift_en", 32'(shift_en), 32'd0);
      checkOutput("s3 stall last", 32'(out_last), 32'd0);
      checkOutput("s3 stall in_ready", 32'(in_ready), 32'd0);
    end
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1);
    checkOutput("s3 resume 5", 32'(out_nibble), 32'h5);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1);
    checkOutput("s3 resume C", 32'(out_nibble), 32'hC);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1);
    checkOutput("s3 resume 3", 32'(out_nibble), 32'h3);
    checkOutput("s3 last", 32'(out_last), 32'd1);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1);
    checkOutput("s3 frame_count", 32'(frame_count), 32'd2);

    // Back-to-back: 1234 offered on the last beat of A5C3
    applyStimulus(1'b0, 1'b1, 16'hA5C3, 1'b1);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1);
    checkOutput("s4 nibble A", 32'(out_nibble), 32'hA);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1);
    checkOutput("s4 nibble 5", 32'(out_nibble), 32'h5);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1);
    checkOutput("s4 nibble C", 32'(out_nibble), 32'hC);
    applyStimulus(1'b0, 1'b1, 16'h1234, 1'b1);
    checkOutput("s4 nibble 3", 32'(out_nibble), 32'h3);
    checkOutput("s4 overlap last", 32'(out_last), 32'd1);
    checkOutput("s4 overlap in_ready", 32'(in_ready), 32'd1);
    checkOutput("s4 overlap load_en", 32'(load_en), 32'd1);
    checkOutput("s4 overlap shift_en", 32'(shift_en), 32'd0);
    word2 = 16'h1234;
    checkFrame("s4 f2", word2);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1);
    checkOutput("s4 frame_count", 32'(frame_count), 32'd4);
    checkOutput("s4 idle out_valid", 32'(out_valid), 32'd0);

    // Reset in the middle of a frame
    applyStimulus(1'b0, 1'b1, 16'hA5C3, 1'b1);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1);
    checkOutput("s5 nibble A", 32'(out_nibble), 32'hA);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1);
    checkOutput("s5 nibble 5", 32'(out_nibble), 32'h5);
    applyStimulus(1'b1, 1'b0, 16'h0000, 1'b1);
    checkOutput("s5 rst out_valid", 32'(out_valid), 32'd0);
    checkOutput("s5 rst shift_en", 32'(shift_en), 32'd0);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1);
    checkOutput("s5 after out_valid", 32'(out_valid), 32'd0);
    checkOutput("s5 after chain_q", 32'(chain_q), 32'h0000);
    checkOutput("s5 after frame_count", 32'(frame_count), 32'd0);
    checkOutput("s5 after in_ready", 32'(in_ready), 32'd1);
    applyStimulus(1'b0, 1'b1, 16'hFFFF, 1'b1);
    checkOutput("s5 load_en", 32'(load_en), 32'd1);
    checkFrame("s5 FFFF", 16'hFFFF);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1);
    checkOutput("s5 frame_count", 32'(frame_count), 32'd1);
`ifdef NIBBLE_SHIFT_ROTATE_EN
    checkOutput("s5 chain_q", 32'(chain_q), 32'hFFFF);
`else
    checkOutput("s5 chain_q", 32'(chain_q), 32'h0000);
`endif

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
